// File: rtl/led_stretch_pwm_pkg.sv
// LED stretcher/PWM shared types.
// Channel state encoding and state decode helpers.
package led_stretch_pwm_pkg;

  typedef enum logic [1:0] {
    LED_OFF      = 2'b00,
    LED_ON_HOLD  = 2'b01,
    LED_ON       = 2'b10,
    LED_OFF_HOLD = 2'b11
  } led_st_e;

  function automatic logic st_lit(led_st_e s);
    return (s == LED_ON_HOLD) || (s == LED_ON);
  endfunction

  function automatic logic st_hold(led_st_e s);
    return (s == LED_ON_HOLD) || (s == LED_OFF_HOLD);
  endfunction

endpackage

// File: rtl/led_stretch_pwm_if.sv
// Pin-side bundle of the LED stretcher/PWM stage.
// master drives core levels and duty; slave drives pins.
interface led_stretch_pwm_if #(
  parameter int NUM_LED = 4,
  parameter int PWM_W   = 4
);
  logic [NUM_LED-1:0] led_i;
  logic [PWM_W-1:0]   duty_i;
  logic [NUM_LED-1:0] led_o;
  logic [NUM_LED-1:0] busy_o;
  logic               tick_o;

  modport master (
    output led_i, duty_i,
    input  led_o, busy_o, tick_o
  );

  modport slave (
    input  led_i, duty_i,
    output led_o, busy_o, tick_o
  );
endinterface

// File: rtl/led_stretch_pwm_chan.sv
// One LED channel: hold FSM plus hold-tick counter.
// Outputs reflect the next state so the top can register them.
module led_chan
  import led_stretch_pwm_pkg::*;
#(
  parameter int MIN_HOLD = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic lvl_i,
  output logic lit_o,
  output logic busy_o
);

  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD = HW'(MIN_HOLD);

  led_st_e st, st_nx;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= LED_OFF;
      hcnt <= '0;
    end else begin
      st   <= st_nx;
      hcnt <= hcnt_nx;
    end
  end

  // expiry reloads before a decrement could wrap hcnt
  assign expire = tick && (hcnt == HW'(1));

  always_comb begin
    st_nx   = st;
    hcnt_nx = hcnt;
    unique case (st)
      LED_OFF: begin
        if (lvl_i) begin
          st_nx   = LED_ON_HOLD;
          hcnt_nx = HOLD;
        end
      end
      LED_ON_HOLD: begin
        if (expire) begin
          if (lvl_i) begin
            st_nx   = LED_ON;
            hcnt_nx = '0;
          end else begin
            st_nx   = LED_OFF_HOLD;
            hcnt_nx = HOLD;
          end
        end else if (tick) begin
          hcnt_nx = hcnt - HW'(1);
        end
      end
      LED_ON: begin
        if (!lvl_i) begin
          st_nx   = LED_OFF_HOLD;
          hcnt_nx = HOLD;
        end
      end
      LED_OFF_HOLD: begin
        if (expire) begin
          if (lvl_i) begin
            st_nx   = LED_ON_HOLD;
            hcnt_nx = HOLD;
          end else begin
            st_nx   = LED_OFF;
            hcnt_nx = '0;
          end
        end else if (tick) begin
          hcnt_nx = hcnt - HW'(1);
        end
      end
    endcase
  end

  assign lit_o  = st_lit(st_nx);
  assign busy_o = st_hold(st_nx);

endmodule

// File: rtl/led_stretch_pwm.sv
// LED output stage: per-channel pulse stretch, shared PWM dimming.
// Prescaler, PWM counter and pin registers live here.
module led_stretch_pwm
  import led_stretch_pwm_pkg::*;
#(
  parameter int NUM_LED  = 4,
  parameter int CLK_DIV  = 50000,
  parameter int MIN_HOLD = 20,
  parameter int PWM_W    = 4
) (
  input logic             clk,
  input logic             rst,
  led_stretch_pwm_if.slave pins
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0]    DIV_TOP = DW'(CLK_DIV - 1);
  localparam logic [PWM_W-1:0] PWM_TOP = ~PWM_W'(1);

  logic [DW-1:0]      div_cnt;
  logic [PWM_W-1:0]   pwm_cnt, pwm_nx;
  logic               tick, pwm_on_nx;
  logic [NUM_LED-1:0] lit_nx, busy_nx;
  logic [NUM_LED-1:0] led_q, busy_q;

  assign tick = (div_cnt == DIV_TOP) && !rst;

  assign pwm_nx = (pwm_cnt == PWM_TOP) ? '0
                                       : pwm_cnt + PWM_W'(1);

  // all-ones duty must stay lit through the count that equals it
  assign pwm_on_nx = (pins.duty_i == '1) ||
                     (pwm_nx < pins.duty_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
      led_q   <= '0;
      busy_q  <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      pwm_cnt <= pwm_nx;
      led_q   <= lit_nx & {NUM_LED{pwm_on_nx}};
      busy_q  <= busy_nx;
    end
  end

  for (genvar g = 0; g < NUM_LED; g++) begin : g_chan
    led_chan #(
      .MIN_HOLD(MIN_HOLD)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .lvl_i (pins.led_i[g]),
      .lit_o (lit_nx[g]),
      .busy_o(busy_nx[g])
    );
  end

  assign pins.led_o  = led_q;
  assign pins.busy_o = busy_q;
  assign pins.tick_o = tick;

endmodule

// File: tb/tb_led_stretch_pwm.sv
// Bench for led_stretch_pwm: vector table through a scoreboard
// queue, plus hand sequences for long holds and PWM duty.
module tb_led_stretch_pwm;

  localparam int CDIV = 4;

  typedef struct {
    int         n;
    logic       r;
    logic [3:0] led;
    logic [2:0] duty;
    logic [3:0] eled;
    logic [3:0] ebusy;
    string      nm;
  } vec_t;

  typedef struct {
    string      nm;
    logic [3:0] led;
    logic [3:0] busy;
    logic [3:0] lm;
    logic [3:0] bm;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  vec_t vt[19];

  led_stretch_pwm_if #(.NUM_LED(4), .PWM_W(3)) pins();

  led_stretch_pwm #(
    .NUM_LED (4),
    .CLK_DIV (CDIV),
    .MIN_HOLD(3),
    .PWM_W   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pins(pins)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h",
               nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) cyc = 0;
    else cyc++;
    #1;
  endtask

  task automatic drive_chk(string nm, logic r, logic [3:0] l,
                           logic [2:0] d, logic [3:0] el,
                           logic [3:0] eb, logic [3:0] lm,
                           logic [3:0] bm);
    exp_t e;
    rst         = r;
    pins.led_i  = l;
    pins.duty_i = d;
    e.nm   = nm;
    e.led  = el;
    e.busy = eb;
    e.lm   = lm;
    e.bm   = bm;
    e.tick = !r && (((cyc + 1) % CDIV) == CDIV - 1);
    sbq.push_back(e);
    step();
    e = sbq.pop_front();
    check({e.nm, " led_o"}, 32'(pins.led_o & e.lm),
          32'(e.led & e.lm));
    check({e.nm, " busy_o"}, 32'(pins.busy_o & e.bm),
          32'(e.busy & e.bm));
    check({e.nm, " tick_o"}, 32'(pins.tick_o), 32'(e.tick));
  endtask

  task automatic pwm_count(logic [2:0] d, int want);
    int hi = 0;
    pins.duty_i = d;
    step();
    step();
    for (int i = 0; i < 14; i++) begin
      step();
      if (pins.led_o[3]) hi++;
    end
    check($sformatf("pwm duty=%0d highs", d), hi, want);
  endtask

  initial begin
    bit rose;
    vt[0]  = '{3,  1'b1, 4'hF, 3'd7, 4'h0, 4'h0, "rst_hold"};
    vt[1]  = '{11, 1'b0, 4'hF, 3'd7, 4'hF, 4'hF, "rel_onhold"};
    vt[2]  = '{1,  1'b0, 4'hF, 3'd7, 4'hF, 4'h0, "rel_on"};
    vt[3]  = '{3,  1'b0, 4'hF, 3'd7, 4'hF, 4'h0, "all_on"};
    vt[4]  = '{12, 1'b0, 4'h0, 3'd7, 4'h0, 4'hF, "offhold_tick"};
    vt[5]  = '{2,  1'b0, 4'h0, 3'd7, 4'h0, 4'h0, "all_off"};
    vt[6]  = '{2,  1'b0, 4'h0, 3'd7, 4'h0, 4'h0, "pre_pulse"};
    vt[7]  = '{1,  1'b0, 4'h1, 3'd7, 4'h1, 4'h1, "pulse_in"};
    vt[8]  = '{11, 1'b0, 4'h0, 3'd7, 4'h1, 4'h1, "pulse_hold"};
    vt[9]  = '{12, 1'b0, 4'h0, 3'd7, 4'h0, 4'h1, "pulse_off"};
    vt[10] = '{1,  1'b0, 4'h0, 3'd7, 4'h0, 4'h0, "pulse_idle"};
    vt[11] = '{11, 1'b0, 4'h4, 3'd7, 4'h4, 4'h4, "c2_onhold"};
    vt[12] = '{1,  1'b0, 4'h4, 3'd7, 4'h4, 4'h0, "c2_on"};
    vt[13] = '{2,  1'b0, 4'h0, 3'd7, 4'h0, 4'h4, "c2_drop"};
    vt[14] = '{9,  1'b0, 4'h4, 3'd7, 4'h0, 4'h4, "c2_rerise"};
    vt[15] = '{1,  1'b0, 4'h4, 3'd7, 4'h4, 4'h4, "c2_expiry"};
    vt[16] = '{2,  1'b0, 4'h0, 3'd7, 4'h4, 4'h4, "c2_ignore"};
    vt[17] = '{1,  1'b1, 4'h0, 3'd7, 4'h0, 4'h0, "mid_rst"};
    vt[18] = '{6,  1'b0, 4'h0, 3'd7, 4'h0, 4'h0, "post_rst"};

    pins.led_i  = 4'hF;
    pins.duty_i = 3'd7;

    for (int v = 0; v < 19; v++)
      for (int k = 0; k < vt[v].n; k++)
        drive_chk(vt[v].nm, vt[v].r, vt[v].led, vt[v].duty,
                  vt[v].eled, vt[v].ebusy, 4'hF, 4'hF);

    // long press on channel 1, then fall and early re-rise
    for (int k = 0; k < 100; k++)
      drive_chk("c1_long", 1'b0, 4'h2, 3'd7, 4'h2, 4'h0,
                4'hF, 4'h0);
    drive_chk("c1_fall", 1'b0, 4'h0, 3'd7, 4'h0, 4'h2,
              4'hF, 4'hF);
    for (int k = 0; k < 8; k++)
      drive_chk("c1_offmin", 1'b0, 4'h2, 3'd7, 4'h0, 4'h2,
                4'hF, 4'hF);
    rose = 1'b0;
    for (int k = 0; k < 4 && !rose; k++) begin
      step();
      rose = pins.led_o[1];
    end
    check("c1_rise_bound", 32'(rose), 32'd1);
    pins.led_i = 4'h0;
    for (int k = 0; k < 30; k++) step();
    drive_chk("c1_settled", 1'b0, 4'h0, 3'd7, 4'h0, 4'h0,
              4'hF, 4'hF);

    // steady-on channel 3 under different duties
    pins.led_i = 4'h8;
    for (int k = 0; k < 14; k++) step();
    drive_chk("c3_on", 1'b0, 4'h8, 3'd7, 4'h8, 4'h0,
              4'hF, 4'hF);
    pwm_count(3'd3, 6);
    pwm_count(3'd0, 0);
    pwm_count(3'd6, 12);
    pwm_count(3'd7, 14);
    drive_chk("c3_busy", 1'b0, 4'h8, 3'd7, 4'h8, 4'h0,
              4'hF, 4'hF);

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
